// File: rtl/alu_issue.sv
// alu_issue: issue/sequencing stage for the integer ALU.
// Accepts one arithmetic bytecode, pops its operands from the operand stack,
// drives the registered ALU operand/op-select inputs, then pushes the result.
// Optional feature macro: ALU_DIVZERO_TRAP_EN. When defined, idiv/irem with a
// zero divisor end in ERR with err_code 3 instead of pushing a result.
module alu_issue #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  input  logic [7:0]         op_code,
  output logic               op_ready,
  input  logic [DEPTH_W-1:0] stack_depth,
  output logic               pop_req,
  input  logic [31:0]        pop_data,
  output logic               push_req,
  output logic [31:0]        push_data,
  output logic [31:0]        alu_operand_a,
  output logic [31:0]        alu_operand_b,
  output logic [3:0]         alu_op_select,
  input  logic [31:0]        alu_result_lo,
  output logic               done,
  output logic               err,
  output logic [1:0]         err_code
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP1 = 3'd1,
    POP2 = 3'd2,
    EXEC = 3'd3,
    PUSH = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd2;
  localparam logic [1:0] ERR_DIVZERO   = 2'd3;

  state_t      state_q;
  logic [3:0]  op_sel_q;
  logic        binary_q;
  logic [31:0] operand_a_q;
  logic [31:0] operand_b_q;
  logic        pop_req_q;
  logic        push_req_q;
  logic        done_q;
  logic        err_q;
  logic [1:0]  err_code_q;
  logic [31:0] push_data_q;

  logic [3:0]  dec_sel;
  logic [1:0]  dec_arity;
  logic        dec_legal;
  logic        div_zero;

  // Bytecode decode: op_select, operand count, and legality.
  always_comb begin
    dec_sel   = 4'd0;
    dec_arity = 2'd0;
    dec_legal = 1'b1;
    case (op_code)
      8'h60: begin dec_sel = 4'd1;  dec_arity = 2'd2; end // iadd
      8'h64: begin dec_sel = 4'd2;  dec_arity = 2'd2; end // isub
      8'h68: begin dec_sel = 4'd3;  dec_arity = 2'd2; end // imul
      8'h6C: begin dec_sel = 4'd4;  dec_arity = 2'd2; end // idiv
      8'h70: begin dec_sel = 4'd5;  dec_arity = 2'd2; end // irem
      8'h74: begin dec_sel = 4'd9;  dec_arity = 2'd1; end // ineg
      8'h78: begin dec_sel = 4'd10; dec_arity = 2'd1; end // ishl
      8'h7A: begin dec_sel = 4'd11; dec_arity = 2'd1; end // ishr
      8'h7E: begin dec_sel = 4'd6;  dec_arity = 2'd2; end // iand
      8'h80: begin dec_sel = 4'd7;  dec_arity = 2'd2; end // ior
      8'h82: begin dec_sel = 4'd8;  dec_arity = 2'd2; end // ixor
      8'h84: begin dec_sel = 4'd0;  dec_arity = 2'd1; end // iinc
      default: dec_legal = 1'b0;
    endcase
  end

  // Divide-by-zero condition; operand_b is already settled on entry to EXEC.
`ifdef ALU_DIVZERO_TRAP_EN
  assign div_zero = binary_q && ((op_sel_q == 4'd4) || (op_sel_q == 4'd5)) &&
                    (operand_b_q == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  // Sequencer: state plus all registered outputs, loaded for the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_sel_q    <= 4'd0;
      binary_q    <= 1'b0;
      operand_a_q <= 32'd0;
      operand_b_q <= 32'd0;
      pop_req_q   <= 1'b0;
      push_req_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      push_data_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (op_valid) begin
            op_sel_q <= dec_sel;
            binary_q <= (dec_arity == 2'd2);
            if (!dec_legal) begin
              state_q    <= ERR;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= ERR_ILLEGAL;
            end else if (stack_depth < DEPTH_W'(dec_arity)) begin
              state_q    <= ERR;
              done_q     <= 1'b1;
              err_q      <= 1'b1;
              err_code_q <= ERR_UNDERFLOW;
            end else begin
              state_q    <= POP1;
              pop_req_q  <= 1'b1;
              err_code_q <= ERR_NONE;
            end
          end
        end
        POP1: begin
          // Second pop only for binary ops; its data lands during EXEC.
          state_q   <= POP2;
          pop_req_q <= binary_q;
        end
        POP2: begin
          // First popped word is the top of stack (value2 for binary ops).
          if (binary_q) operand_b_q <= pop_data;
          else          operand_a_q <= pop_data;
          pop_req_q <= 1'b0;
          state_q   <= EXEC;
        end
        EXEC: begin
          if (binary_q) operand_a_q <= pop_data;
          if (div_zero) begin
            state_q    <= ERR;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
            err_code_q <= ERR_DIVZERO;
          end else begin
            state_q    <= PUSH;
            push_req_q <= 1'b1;
            done_q     <= 1'b1;
          end
        end
        PUSH: begin
          push_data_q <= alu_result_lo;
          push_req_q  <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= IDLE;
        end
        ERR: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          pop_req_q  <= 1'b0;
          push_req_q <= 1'b0;
          done_q     <= 1'b0;
          err_q      <= 1'b0;
        end
      endcase
    end
  end

  assign op_ready      = (state_q == IDLE);
  assign pop_req       = pop_req_q;
  assign push_req      = push_req_q;
  // The ALU is combinational on the registered operands, so the result is
  // forwarded during PUSH and held afterwards.
  assign push_data     = push_req_q ? alu_result_lo : push_data_q;
  assign alu_operand_a = operand_a_q;
  assign alu_operand_b = operand_b_q;
  assign alu_op_select = op_sel_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed testbench for alu_issue with a behavioural operand stack and ALU.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [7:0]  op_code = 8'h00;
  logic        op_ready;
  logic [7:0]  stack_depth;
  logic        pop_req;
  logic [31:0] pop_data;
  logic        push_req;
  logic [31:0] push_data;
  logic [31:0] alu_operand_a;
  logic [31:0] alu_operand_b;
  logic [3:0]  alu_op_select;
  logic [31:0] alu_result_lo;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_issue #(.DEPTH_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .op_valid      (op_valid),
    .op_code       (op_code),
    .op_ready      (op_ready),
    .stack_depth   (stack_depth),
    .pop_req       (pop_req),
    .pop_data      (pop_data),
    .push_req      (push_req),
    .push_data     (push_data),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_op_select (alu_op_select),
    .alu_result_lo (alu_result_lo),
    .done          (done),
    .err           (err),
    .err_code      (err_code)
  );

  // Operand stack model: pop data appears the cycle after pop_req.
  logic [31:0] stk [0:15];
  int          sp = 0;
  logic [31:0] pop_data_r = 32'd0;
  logic        tb_push = 1'b0;
  logic        tb_clear = 1'b0;
  logic [31:0] tb_val = 32'd0;

  always @(posedge clk) begin
    if (tb_clear) sp <= 0;
    else if (tb_push) begin
      stk[4'(sp)] <= tb_val;
      sp <= sp + 1;
    end else if (push_req) begin
      stk[4'(sp)] <= push_data;
      sp <= sp + 1;
    end else if (pop_req) begin
      pop_data_r <= stk[4'(sp - 1)];
      sp <= sp - 1;
    end
  end
  assign pop_data    = pop_data_r;
  assign stack_depth = 8'(sp);

  // Combinational ALU model driven from the DUT's registered inputs.
  always_comb begin
    alu_result_lo = 32'd0;
    case (alu_op_select)
      4'd0:  alu_result_lo = alu_operand_a + 32'd1;
      4'd1:  alu_result_lo = alu_operand_a + alu_operand_b;
      4'd2:  alu_result_lo = alu_operand_a - alu_operand_b;
      4'd3:  alu_result_lo = alu_operand_a * alu_operand_b;
      4'd4:  alu_result_lo = (alu_operand_b == 32'd0) ? 32'd0 :
                             32'($signed(alu_operand_a) / $signed(alu_operand_b));
      4'd5:  alu_result_lo = (alu_operand_b == 32'd0) ? 32'd0 :
                             32'($signed(alu_operand_a) % $signed(alu_operand_b));
      4'd6:  alu_result_lo = alu_operand_a & alu_operand_b;
      4'd7:  alu_result_lo = alu_operand_a | alu_operand_b;
      4'd8:  alu_result_lo = alu_operand_a ^ alu_operand_b;
      4'd9:  alu_result_lo = 32'd0 - alu_operand_a;
      4'd10: alu_result_lo = alu_operand_a << 1;
      4'd11: alu_result_lo = 32'($signed(alu_operand_a) >>> 1);
      default: alu_result_lo = 32'd0;
    endcase
  end

  // push and pop must never coincide.
  logic overlap_seen = 1'b0;
  always @(negedge clk) if (pop_req && push_req) overlap_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
  endtask

  task automatic stack_clear();
    @(negedge clk); tb_clear = 1'b1;
    @(negedge clk); tb_clear = 1'b0;
  endtask

  task automatic stack_push(input logic [31:0] v);
    @(negedge clk); tb_push = 1'b1; tb_val = v;
    @(negedge clk); tb_push = 1'b0;
  endtask

  // Issue one bytecode and record outputs for cycles 1..5 (bit k = cycle k).
  task automatic run_op(input logic [7:0] code, input string name,
                        output logic [5:0] popm, output logic [5:0] pushm,
                        output logic [5:0] donem, output logic [5:0] errm,
                        output logic [31:0] pdata, output logic [3:0] psel,
                        output logic [1:0] ecode);
    popm = '0; pushm = '0; donem = '0; errm = '0; pdata = '0; psel = '0;
    @(negedge clk);
    op_valid = 1'b1; op_code = code;
    @(posedge clk); #1;
    op_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      popm[k]  = pop_req;
      pushm[k] = push_req;
      donem[k] = done;
      errm[k]  = err;
      if (push_req) begin
        pdata = push_data;
        psel  = alu_op_select;
      end
      if (k == 1) ecode = err_code;
      if (k < 5) begin
        @(posedge clk); #1;
      end
    end
    ecode = err_code;
    $display("op %s code=0x%02h pop=%b push=%b done=%b err=%b data=0x%08h err_code=%0d",
             name, code, popm, pushm, donem, errm, pdata, ecode);
  endtask

  logic [5:0]  popm, pushm, donem, errm;
  logic [31:0] pdata;
  logic [3:0]  psel;
  logic [1:0]  ecode;

  initial begin
    // Reset and check reset values.
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_op_ready", 32'(op_ready), 32'd1);
    check("rst_pop_req",  32'(pop_req), 32'd0);
    check("rst_push_req", 32'(push_req), 32'd0);
    check("rst_push_data", push_data, 32'd0);
    check("rst_operand_a", alu_operand_a, 32'd0);
    check("rst_operand_b", alu_operand_b, 32'd0);
    check("rst_op_select", 32'(alu_op_select), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);

    // iadd: 5 + 7 = 12.
    stack_clear(); stack_push(32'd5); stack_push(32'd7);
    run_op(8'h60, "iadd", popm, pushm, donem, errm, pdata, psel, ecode);
    check("iadd_pop_cycles",  32'(popm),  32'b000110);
    check("iadd_push_cycles", 32'(pushm), 32'b010000);
    check("iadd_done_cycles", 32'(donem), 32'b010000);
    check("iadd_err_cycles",  32'(errm),  32'b000000);
    check("iadd_push_data", pdata, 32'h0000000C);
    check("iadd_err_code", 32'(ecode), 32'd0);

    // isub: 10 - 3 = 7 (value1 - value2).
    stack_clear(); stack_push(32'd10); stack_push(32'd3);
    run_op(8'h64, "isub", popm, pushm, donem, errm, pdata, psel, ecode);
    check("isub_push_data", pdata, 32'h00000007);
    check("isub_op_select", 32'(psel), 32'd2);

    // ineg 0 -> 0xFFFFFFFF? no: -0 = 0; use 1 -> 0xFFFFFFFF.
    stack_clear(); stack_push(32'd1);
    run_op(8'h74, "ineg", popm, pushm, donem, errm, pdata, psel, ecode);
    check("ineg_pop_cycles",  32'(popm),  32'b000010);
    check("ineg_push_cycles", 32'(pushm), 32'b010000);
    check("ineg_push_data", pdata, 32'hFFFFFFFF);

    // ineg of 0 yields 0 through the unary path.
    stack_clear(); stack_push(32'd0);
    run_op(8'h74, "ineg0", popm, pushm, donem, errm, pdata, psel, ecode);
    check("ineg0_push_data", pdata, 32'h00000000);
    check("ineg0_op_select", 32'(psel), 32'd9);

    // iadd with only one entry: underflow.
    stack_clear(); stack_push(32'd4);
    run_op(8'h60, "iadd_uflow", popm, pushm, donem, errm, pdata, psel, ecode);
    check("uflow_pop_cycles",  32'(popm),  32'b000000);
    check("uflow_done_cycles", 32'(donem), 32'b000010);
    check("uflow_err_cycles",  32'(errm),  32'b000010);
    check("uflow_err_code", 32'(ecode), 32'd2);
    check("uflow_depth_kept", 32'(stack_depth), 32'd1);

    // Illegal opcode 0x00.
    run_op(8'h00, "illegal", popm, pushm, donem, errm, pdata, psel, ecode);
    check("illegal_pop_cycles",  32'(popm),  32'b000000);
    check("illegal_err_cycles",  32'(errm),  32'b000010);
    check("illegal_err_code", 32'(ecode), 32'd1);

    // idiv 9 / 0.
    stack_clear(); stack_push(32'd9); stack_push(32'd0);
    run_op(8'h6C, "idiv0", popm, pushm, donem, errm, pdata, psel, ecode);
    check("div0_pop_cycles",  32'(popm),  32'b000110);
    check("div0_done_cycles", 32'(donem), 32'b010000);
`ifdef ALU_DIVZERO_TRAP_EN
    check("div0_push_cycles", 32'(pushm), 32'b000000);
    check("div0_err_cycles",  32'(errm),  32'b010000);
    check("div0_err_code", 32'(ecode), 32'd3);
`else
    check("div0_push_cycles", 32'(pushm), 32'b010000);
    check("div0_err_cycles",  32'(errm),  32'b000000);
    check("div0_err_code", 32'(ecode), 32'd0);
`endif

    // Reset asserted during EXEC of iadd.
    stack_clear(); stack_push(32'd5); stack_push(32'd7);
    @(negedge clk);
    op_valid = 1'b1; op_code = 8'h60;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("exec_op_ready", 32'(op_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_pop_req",  32'(pop_req), 32'd0);
    check("midrst_push_req", 32'(push_req), 32'd0);
    check("midrst_operand_a", alu_operand_a, 32'd0);
    check("midrst_operand_b", alu_operand_b, 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    begin
      logic push_after;
      push_after = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_op_ready", 32'(op_ready), 32'd1);
      for (int k = 0; k < 6; k++) begin
        if (push_req || done) push_after = 1'b1;
        @(posedge clk); #1;
      end
      check("midrst_no_push", 32'(push_after), 32'd0);
      $display("op midrst iadd reset in EXEC, push_or_done_after=%0b", push_after);
    end

    check("no_push_pop_overlap", 32'(overlap_seen), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
